// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit 5-stage pipeline control blocks.
//   fwd_sel_t : operand source select driven into ID/EX
//   state_t   : redirect-flush sequencer states
//   slot_t    : one in-flight scoreboard entry {valid, wr, rd, is_load}
//   REG_ADDR_W: build-wide register-address width
package cpu_pkg;

  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
  } slot_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand hazard/forward compare (purely combinational).
// Build option: HAZARD_ZERO_REG_EN -- r0 is hardwired zero, so a write to r0
// never matches (no stall, no forward).
// Ports:
//   rs, uses                               : operand register and use flag
//   ex_valid, ex_wr, ex_rd, ex_is_load     : EX scoreboard slot
//   mem_valid, mem_wr, mem_rd              : MEM scoreboard slot
//   fwd                                    : operand source select
//   load_use                               : operand needs the load still in EX
module hazard_fwd_sel #(
  parameter int REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  uses,
  input  logic                  ex_valid,
  input  logic                  ex_wr,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  mem_valid,
  input  logic                  mem_wr,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  output logic [1:0]            fwd,
  output logic                  load_use
);
  import cpu_pkg::*;

`ifdef HAZARD_ZERO_REG_EN
  localparam logic ZERO_HARD = 1'b1;
`else
  localparam logic ZERO_HARD = 1'b0;
`endif

  logic     rs_ignored;
  logic     ex_hit;
  logic     mem_hit;
  fwd_sel_t sel;

  assign rs_ignored = ZERO_HARD & (rs == '0);
  assign ex_hit     = ex_valid  & ex_wr  & (ex_rd  == rs) & ~rs_ignored;
  assign mem_hit    = mem_valid & mem_wr & (mem_rd == rs) & ~rs_ignored;

  // A load in EX has no result yet: it cannot forward from EX, and it also
  // shadows any older MEM writer of the same register, so select RF and let
  // the load-use stall hold the instruction for one cycle.
  always_comb begin
    sel = FWD_RF;
    if (uses) begin
      if (ex_hit && !ex_is_load) sel = FWD_EXMEM;
      else if (!ex_hit && mem_hit) sel = FWD_MEMWB;
    end
  end

  assign fwd      = sel;
  assign load_use = uses & ex_hit & ex_is_load;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller beside the ID stage.
// Tracks in-flight destinations (EX, MEM, WB), raises a one-bubble stall on
// load-use, selects forwarding sources and sequences redirect flushes.
// Build option: HAZARD_ZERO_REG_EN (r0 hardwired zero, see hazard_fwd_sel).
// Ports:
//   clk, rst (sync, active-high)
//   id_*      : decoded ID-stage instruction fields
//   ex_taken  : redirect resolved taken in EX this cycle
//   stall/pc_hold/ifid_hold : load-use bubble and front-end hold
//   flush     : IF/ID squash
//   forward_a/forward_b     : 00 regfile, 01 EX/MEM, 10 MEM/WB
//   busy      : flush sequencer not in RUN
// REG_ADDR_W must equal cpu_pkg::REG_ADDR_W (scoreboard slot width).
module hazard_ctrl #(
  parameter int REG_ADDR_W   = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs_a,
  input  logic [REG_ADDR_W-1:0] id_rs_b,
  input  logic                  id_uses_a,
  input  logic                  id_uses_b,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wr_en,
  input  logic                  id_is_load,
  input  logic                  ex_taken,
  output logic                  stall,
  output logic                  pc_hold,
  output logic                  ifid_hold,
  output logic                  flush,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  busy
);
  import cpu_pkg::*;

  localparam logic [1:0] CNT_LOAD = 2'(FLUSH_CYCLES - 1);

  // Scoreboard: index 0 = EX, 1 = MEM, 2 = WB
  slot_t      sb [0:2];
  state_t     state, state_nx;
  logic [1:0] cnt, cnt_nx;

  logic [1:0] fwd_a, fwd_b;
  logic       lu_a, lu_b;
  logic       lu, flush_raw, stall_raw, accept;

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
    .rs(id_rs_a), .uses(id_uses_a),
    .ex_valid(sb[0].valid), .ex_wr(sb[0].wr), .ex_rd(sb[0].rd),
    .ex_is_load(sb[0].is_load),
    .mem_valid(sb[1].valid), .mem_wr(sb[1].wr), .mem_rd(sb[1].rd),
    .fwd(fwd_a), .load_use(lu_a)
  );

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
    .rs(id_rs_b), .uses(id_uses_b),
    .ex_valid(sb[0].valid), .ex_wr(sb[0].wr), .ex_rd(sb[0].rd),
    .ex_is_load(sb[0].is_load),
    .mem_valid(sb[1].valid), .mem_wr(sb[1].wr), .mem_rd(sb[1].rd),
    .fwd(fwd_b), .load_use(lu_b)
  );

  // Flush wins over stall: a squashed ID instruction needs no bubble.
  assign lu        = id_valid & (lu_a | lu_b);
  assign flush_raw = ex_taken | ((state == FLUSH) && (cnt != 2'd0));
  assign stall_raw = lu & ~flush_raw;
  assign accept    = id_valid & ~stall_raw & ~flush_raw;

  always_comb begin
    stall     = 1'b0;
    pc_hold   = 1'b0;
    ifid_hold = 1'b0;
    flush     = 1'b0;
    forward_a = FWD_RF;
    forward_b = FWD_RF;
    busy      = 1'b0;
    if (!rst) begin
      stall     = stall_raw;
      pc_hold   = stall_raw;
      ifid_hold = stall_raw;
      flush     = flush_raw;
      forward_a = fwd_a;
      forward_b = fwd_b;
      busy      = (state != RUN);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      RUN: begin
        if (ex_taken) begin
          state_nx = FLUSH;
          cnt_nx   = CNT_LOAD;
        end
      end
      FLUSH: begin
        if (ex_taken)          cnt_nx   = CNT_LOAD;
        else if (cnt == 2'd0)  state_nx = RUN;
        else                   cnt_nx   = cnt - 2'd1;
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = 2'd0;
      end
    endcase
  end

  // ---- ID -> EX -> MEM -> WB scoreboard and sequencer registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) sb[i] <= '0;
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      if (accept) sb[0] <= '{valid: 1'b1, wr: id_wr_en, rd: id_rd, is_load: id_is_load};
      else        sb[0] <= '0;
      sb[1] <= sb[0];
      sb[2] <= sb[1];
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule
